// File: rtl/spi_periph_pkg.sv
// Shared definitions for the memory-mapped SPI master: register word offsets,
// STATUS bit positions, engine state encoding and soft-reset timing.
package spi_periph_pkg;

    // Register word offsets (byte address >> 2)
    localparam logic [7:0] REG_CTRL   = 8'd0;
    localparam logic [7:0] REG_TX     = 8'd1;
    localparam logic [7:0] REG_RX     = 8'd2;
    localparam logic [7:0] REG_STATUS = 8'd3;

    // CTRL write bit that requests a soft reset
    localparam int CTRL_SOFT_RST_BIT = 1;

    // STATUS bit positions
    localparam int STAT_BUSY       = 0;
    localparam int STAT_DONE       = 1;
    localparam int STAT_READY      = 2;
    localparam int STAT_TX_DROPPED = 3;

    // Cycles from the soft-reset strobe until ready is raised
    localparam int SOFT_RST_CYCLES = 4;

    // One byte = 8 SPI clock pulses = 16 spi_clk toggles
    localparam int TOGGLES_PER_XFER = 16;

    typedef enum logic [1:0] {
        ENG_IDLE  = 2'd0,
        ENG_SHIFT = 2'd1,
        ENG_DONE  = 2'd2
    } eng_state_e;

    // Packs the status flags into the STATUS read word
    function automatic logic [31:0] status_word(input logic busy,
                                                input logic done,
                                                input logic ready,
                                                input logic tx_dropped);
        logic [31:0] w;
        w                  = 32'd0;
        w[STAT_BUSY]       = busy;
        w[STAT_DONE]       = done;
        w[STAT_READY]      = ready;
        w[STAT_TX_DROPPED] = tx_dropped;
        return w;
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// 8-bit MSB-first SPI shift engine. Each synchronised rclk rising edge toggles
// spi_clk; a byte is exactly 16 toggles. CPOL sets the idle level, CPHA selects
// whether the leading (0) or trailing (1) edge samples spi_miso.
module spi_shift_engine
    import spi_periph_pkg::*;
#(
    parameter logic CPOL = 1'b0,
    parameter logic CPHA = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rclk_rise,
    input  logic       abort,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       spi_miso,
    output logic       spi_clk,
    output logic       spi_mosi,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data
);

    eng_state_e  state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        done_q, done_d;
    logic [7:0]  rx_q, rx_d;
    logic        leading_edge;
    logic        sample_edge;

    // Next-state logic: load on start, toggle/shift on rclk edges, abort on soft reset
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        done_d       = done_q;
        rx_d         = rx_q;
        leading_edge = 1'b0;
        sample_edge  = 1'b0;

        if (abort) begin
            // Soft reset drops the transfer and parks the clock at its idle level
            state_d = ENG_IDLE;
            sclk_d  = CPOL;
            cnt_d   = 5'd0;
            done_d  = 1'b0;
            rx_d    = 8'd0;
        end else begin
            case (state_q)
                ENG_IDLE, ENG_DONE: begin
                    // DONE lasts one cycle but must still accept a new start,
                    // since busy is already low there
                    state_d = ENG_IDLE;
                    if (start) begin
                        shift_d = tx_data;
                        cnt_d   = 5'd0;
                        done_d  = 1'b0;
                        state_d = ENG_SHIFT;
                        // With CPHA=0 the first leading edge samples, so bit 7
                        // must already be on the wire
                        if (!CPHA) begin
                            mosi_d = tx_data[7];
                        end
                    end
                end
                ENG_SHIFT: begin
                    if (rclk_rise) begin
                        sclk_d       = ~sclk_q;
                        cnt_d        = cnt_q + 5'd1;
                        leading_edge = (sclk_q == CPOL);
                        sample_edge  = leading_edge ^ CPHA;
                        if (sample_edge) begin
                            shift_d = {shift_q[6:0], spi_miso};
                        end else if (cnt_d != 5'(TOGGLES_PER_XFER)) begin
                            // The final shifting edge presents nothing: mosi
                            // keeps the last data bit
                            mosi_d = shift_q[7];
                        end
                        if (cnt_d == 5'(TOGGLES_PER_XFER)) begin
                            state_d = ENG_DONE;
                            rx_d    = shift_d;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ENG_IDLE;
                end
            endcase
        end
    end

    // Control and visible outputs, cleared by hard reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ENG_IDLE;
            cnt_q   <= 5'd0;
            sclk_q  <= CPOL;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            rx_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
        end
    end

    // Shift register is pure data; it is always loaded before use
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
    assign busy     = (state_q == ENG_SHIFT);
    assign done     = done_q;
    assign rx_data  = rx_q;

endmodule

// File: rtl/spi_master_peripheral.sv
// Memory-mapped SPI master peripheral: bus decode with write-strobe edge
// detection, rclk synchroniser, soft-reset sequencing, status flags and a
// registered read port. Shifting is done by spi_shift_engine.
module spi_master_peripheral
    import spi_periph_pkg::*;
#(
    parameter logic CPOL = 1'b0,
    parameter logic CPHA = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rclk,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    input  logic [7:0]  mem_addr,
    input  logic [3:0]  mem_wr_en,
    input  logic [31:0] mem_wr_data,
    output logic [31:0] mem_rd_data
);

    // rclk_sync_q[0..1] is the 2-FF synchroniser, [2] holds the previous value
    logic [2:0]  rclk_sync_q, rclk_sync_d;
    logic        wr_en_q, wr_en_d;
    logic        ready_q, ready_d;
    logic        tx_dropped_q, tx_dropped_d;
    logic [2:0]  srst_cnt_q, srst_cnt_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic        rclk_rise;
    logic        wr_stb;
    logic        soft_rst;
    logic        tx_wr;
    logic        tx_accept;
    logic        eng_busy;
    logic        eng_done;
    logic [7:0]  eng_rx;
    logic        unused_bus_bits;

    // Only byte lane 0 and write enable bit 0 carry meaning
    assign unused_bus_bits = &{1'b0, mem_wr_en[3:1], mem_wr_data[31:8]};

    // Strobe decode: a held enable produces a single strobe on its first cycle
    always_comb begin
        rclk_sync_d = {rclk_sync_q[1:0], rclk};
        rclk_rise   = rclk_sync_q[1] & ~rclk_sync_q[2];
        wr_en_d     = mem_wr_en[0];
        wr_stb      = mem_wr_en[0] & ~wr_en_q;
        soft_rst    = wr_stb && (mem_addr == REG_CTRL) && mem_wr_data[CTRL_SOFT_RST_BIT];
        tx_wr       = wr_stb && (mem_addr == REG_TX);
        // Soft reset wins over a coincident TX write
        tx_accept   = tx_wr && ready_q && !eng_busy && !soft_rst;
    end

    // Ready sequencing after soft reset and sticky tx_dropped flag
    always_comb begin
        ready_d      = ready_q;
        tx_dropped_d = tx_dropped_q;
        srst_cnt_d   = srst_cnt_q;

        if (srst_cnt_q != 3'd0) begin
            srst_cnt_d = srst_cnt_q - 3'd1;
            if (srst_cnt_q == 3'd1) begin
                ready_d = 1'b1;
            end
        end

        if (soft_rst) begin
            ready_d      = 1'b0;
            tx_dropped_d = 1'b0;
            srst_cnt_d   = 3'(SOFT_RST_CYCLES);
        end

        // A rejected TX write is recorded even if a soft reset clears it this cycle
        if (tx_wr && !tx_accept) begin
            tx_dropped_d = 1'b1;
        end
    end

    // Read mux, registered for one cycle of latency
    always_comb begin
        rd_data_d = 32'd0;
        case (mem_addr)
            REG_RX:     rd_data_d = {24'd0, eng_rx};
            REG_STATUS: rd_data_d = status_word(eng_busy, eng_done, ready_q, tx_dropped_q);
            default:    rd_data_d = 32'd0;
        endcase
    end

    // Peripheral state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rclk_sync_q  <= 3'd0;
            wr_en_q      <= 1'b0;
            ready_q      <= 1'b0;
            tx_dropped_q <= 1'b0;
            srst_cnt_q   <= 3'd0;
            rd_data_q    <= 32'd0;
        end else begin
            rclk_sync_q  <= rclk_sync_d;
            wr_en_q      <= wr_en_d;
            ready_q      <= ready_d;
            tx_dropped_q <= tx_dropped_d;
            srst_cnt_q   <= srst_cnt_d;
            rd_data_q    <= rd_data_d;
        end
    end

    spi_shift_engine #(
        .CPOL (CPOL),
        .CPHA (CPHA)
    ) u_engine (
        .clk       (clk),
        .rst       (rst),
        .rclk_rise (rclk_rise),
        .abort     (soft_rst),
        .start     (tx_accept),
        .tx_data   (mem_wr_data[7:0]),
        .spi_miso  (spi_miso),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .busy      (eng_busy),
        .done      (eng_done),
        .rx_data   (eng_rx)
    );

    assign mem_rd_data = rd_data_q;

endmodule

// File: tb/tb_spi_master_peripheral.sv
// Directed and randomized bench for spi_master_peripheral (CPOL=0, CPHA=0).
// The reference expects mosi to carry the TX byte MSB first at spi_clk rising
// edges and RX to equal the byte presented on miso, one bit per pulse.
module tb_spi_master_peripheral;
    import spi_periph_pkg::*;

    logic        clk = 1'b0;
    logic        rclk = 1'b0;
    logic        rst;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    int checks = 0;
    int errors = 0;

    // SPI-side observation: pulse counters, mosi log and miso byte model
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    int   rise_base = 0;
    int   fall_base = 0;
    int   miso_idx;
    logic [7:0] miso_byte = 8'h00;
    logic mosi_log [16];
    time  t_start;

    spi_master_peripheral #(
        .CPOL (1'b0),
        .CPHA (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rclk        (rclk),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;
    always #25 rclk = ~rclk;   // rclk = clk/5

    // Log mosi at every rising spi_clk edge of the current transfer
    always @(posedge spi_clk) begin
        if ((rise_cnt - rise_base) >= 0 && (rise_cnt - rise_base) < 16)
            mosi_log[4'(rise_cnt - rise_base)] <= spi_mosi;
        rise_cnt <= rise_cnt + 1;
    end

    always @(negedge spi_clk) begin
        fall_cnt <= fall_cnt + 1;
    end

    // Slave model: bit 7 before the first pulse, next bit after each falling edge
    always_comb begin
        miso_idx = fall_cnt - fall_base;
        spi_miso = (miso_idx >= 0 && miso_idx < 8) ? miso_byte[3'(7 - miso_idx)] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_addr    = a;
        mem_wr_data = d;
        mem_wr_en   = 4'h1;
        repeat (4) @(negedge clk);
        mem_wr_en   = 4'h0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        mem_addr = a;
        @(posedge clk);
        #1 d = mem_rd_data;
    endtask

    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] mi);
        rise_base = rise_cnt;
        fall_base = fall_cnt;
        miso_byte = mi;
        t_start   = $time;
        bus_write(REG_TX, {24'h0, tx});
    endtask

    task automatic finish_xfer(input string tag, input logic [7:0] tx,
                               input logic [7:0] mi, input logic exp_drop);
        logic [31:0] st;
        logic        ok;
        ok = 1'b0;
        for (int i = 0; i < 120; i++) begin
            bus_read(REG_STATUS, st);
            if (!st[STAT_BUSY]) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
        check({tag, "_done_in_100"}, {31'd0, (($time - t_start) / 10) <= 100}, 32'd1);
        check({tag, "_status"}, st, status_word(1'b0, 1'b1, 1'b1, exp_drop));
        repeat (20) @(negedge clk);
        check({tag, "_pulses"}, 32'(rise_cnt - rise_base), 32'd8);
        for (int i = 0; i < 8; i++)
            check({tag, "_mosi_bit"}, {31'd0, mosi_log[i]}, {31'd0, tx[7 - i]});
        check({tag, "_spi_clk_idle"}, {31'd0, spi_clk}, 32'd0);
        bus_read(REG_RX, st);
        check({tag, "_rx"}, st, {24'h0, mi});
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] st;
        logic [7:0]  tx;
        logic [7:0]  mi;
        logic        ok;
        int          r;

        rst         = 1'b0;
        mem_addr    = 8'd0;
        mem_wr_en   = 4'h0;
        mem_wr_data = 32'd0;

        // 1: hard reset state
        repeat (3) @(negedge clk);
        check("rst_spi_clk", {31'd0, spi_clk}, 32'd0);
        check("rst_spi_mosi", {31'd0, spi_mosi}, 32'd0);
        check("rst_rd_data", mem_rd_data, 32'd0);
        rst = 1'b1;
        bus_read(REG_STATUS, st);
        check("rst_status", st, 32'h0);
        bus_read(REG_RX, st);
        check("rst_rx", st, 32'h0);
        bus_read(REG_CTRL, st);
        check("ctrl_reads_zero", st, 32'h0);

        // 1: TX while not ready is dropped, no spi_clk activity
        r = rise_cnt;
        bus_write(REG_TX, 32'h55);
        repeat (100) @(negedge clk);
        check("notready_no_pulses", 32'(rise_cnt - r), 32'd0);
        bus_read(REG_STATUS, st);
        check("notready_status", st, 32'h8);

        // 2: soft reset raises ready and clears tx_dropped
        t_start = $time;
        bus_write(REG_CTRL, 32'h2);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_read(REG_STATUS, st);
            if (st[STAT_READY]) begin
                ok = 1'b1;
                break;
            end
        end
        check("srst_ready_seen", {31'd0, ok}, 32'd1);
        check("srst_status", st, 32'h4);
        bus_read(8'd7, st);
        check("unmapped_reads_zero", st, 32'h0);

        // 3: directed transfer 0xCA with miso held low
        start_xfer(8'hCA, 8'h00);
        bus_read(REG_STATUS, st);
        check("xfer_ca_busy", {31'd0, st[STAT_BUSY]}, 32'd1);
        finish_xfer("xfer_ca", 8'hCA, 8'h00, 1'b0);

        // 4: miso tied high, TX 0x00
        start_xfer(8'h00, 8'hFF);
        finish_xfer("xfer_ff", 8'h00, 8'hFF, 1'b0);

        // 5: TX write during busy is dropped, transfer unaffected
        tx = 8'($urandom);
        mi = 8'($urandom);
        start_xfer(tx, mi);
        repeat (20) @(negedge clk);
        bus_write(REG_TX, {24'h0, ~tx});
        finish_xfer("xfer_busy_wr", tx, mi, 1'b1);

        // 6: soft reset after 3 bits aborts the transfer
        start_xfer(8'($urandom), 8'($urandom));
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((rise_cnt - rise_base) >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_3bits_seen", {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk);
        bus_write(REG_CTRL, 32'h2);
        check("abort_spi_clk_idle", {31'd0, spi_clk}, 32'd0);
        r = rise_cnt;
        repeat (100) @(negedge clk);
        check("abort_no_pulses", 32'(rise_cnt - r), 32'd0);
        bus_read(REG_STATUS, st);
        check("abort_status", st, 32'h4);
        bus_read(REG_RX, st);
        check("abort_rx_cleared", st, 32'h0);

        // Randomized transfers after the abort
        for (int k = 0; k < 4; k++) begin
            tx = 8'($urandom);
            mi = 8'($urandom);
            start_xfer(tx, mi);
            finish_xfer("xfer_rand", tx, mi, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
